fpu_issue_arbiter: RTL and testbench
====================================

Name: fpu_issue_arbiter

Overview:
- Shares one pipelined FMA datapath (the fpu1/fpu2/fpu3 chain) among NREQ requesters.
- Accepts one operation per cycle using round-robin arbitration.
- Tracks in-flight operations with a requester-ID shift pipeline matched to the FPU latency, then steers each result into that requester's response FIFO.
- The FPU cannot stall, so per-requester credits guarantee a FIFO slot exists before an operation is issued.

Parameters:
- NREQ, 4: number of requesters.
- LAT, 2: clock edges from operands presented on fpu_* to a valid fpu_exd.
- QDEPTH, 4: response FIFO depth per requester; also the credit limit.
- IDW, 2: requester-ID width, equal to clog2(NREQ).

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_op  in  2*NREQ  op per requester, packed with requester i at bits [2i+1:2i].
- req_ex1  in  32*NREQ  operand 1, packed.
- req_ex2  in  32*NREQ  operand 2, packed.
- req_ex3  in  32*NREQ  operand 3, packed.
- rsp_valid  out  NREQ  response available.
- rsp_ready  in  NREQ  response consumed.
- rsp_data  out  32*NREQ  FIFO head per requester.
- fpu_op  out  2  registered op to the FPU.
- fpu_ex1  out  32  registered operand to the FPU.
- fpu_ex2  out  32  registered operand to the FPU.
- fpu_ex3  out  32  registered operand to the FPU.
- fpu_issue  out  1  registered; high during cycles carrying a real operation.
- fpu_exd  in  32  FPU result.

Behaviour:
- Reset (asynchronous, active-high). Clears immediately:
  - fpu_op, fpu_ex1..3, fpu_issue -> 0.
  - The tag pipeline (LAT+1 entries of valid+ID) -> all invalid.
  - All FIFOs -> empty, so rsp_valid = 0; rsp_data = 0 when empty.
  - All credit counters -> 0.
  - Round-robin pointer -> 0.
- Reset mid-operation: in-flight operations are discarded. An fpu_exd arriving after reset is never captured.
- Eligibility: elig[i] = req_valid[i] & (cnt[i] < QDEPTH), where cnt[i] is registered (in-flight + FIFO occupancy, range 0..QDEPTH).
- Grant: first eligible i searching upward from the pointer, with wrap-around.
  - req_ready = grant; it is combinational from req_valid and registered state.
  - Handshake occurs at the edge where req_valid[i] & req_ready[i].
  - After a grant to i, the pointer becomes (i+1) mod NREQ. The pointer is unchanged when nothing is granted.
- Issue, on a handshake at edge t:
  - fpu_* take requester i's operands; fpu_issue = 1.
  - tag[0] = {1, i}.
  - With no grant: fpu_issue = 0 and operands are driven to 0.
- Tag pipeline: shifts every cycle. The tag issued at edge t reaches the tail at edge t+LAT, aligned with a valid fpu_exd.
- Capture: at edge t+LAT+1, fpu_exd is pushed into FIFO[ID]. rsp_valid[ID] rises after that edge, giving LAT+1 edges from accept to response.
- Throughput: one issue per cycle with no bubbles.
- Ordering: results are in order per requester. Nothing is ordered across requesters.
- Credits:
  - cnt[i] increments on a grant to i and decrements on a pop (rsp_valid[i] & rsp_ready[i]).
  - On a simultaneous grant and pop, cnt is unchanged.
  - A push never changes cnt.
  - A pop at cnt = QDEPTH does not enable a grant in the same cycle, because eligibility uses the registered cnt.
  - Overflow is impossible by construction. A push to a full FIFO is an assertion failure.
- FIFO: QDEPTH entries with wrapping read/write pointers. Push and pop in the same cycle are legal when the FIFO is not empty.

Test Plan:
1. Single requester, latency and data.
   - Stimulus: requester 0, op=0, ex1=ex2=ex3=3f800000, accepted at edge 0, rsp_ready=1.
   - Required: fpu_issue=1 during cycle 0-1; rsp_valid[0] rises after edge 3 with rsp_data[31:0]=40000000.
2. Full contention.
   - Stimulus: all four req_valid held high, rsp_ready all 1.
   - Required: grants 0,1,2,3,0,1,... on consecutive edges; fpu_issue stays high; each requester gets one response every 4 cycles.
3. Backpressure.
   - Stimulus: rsp_ready[1]=0, all requesters valid.
   - Required: requester 1 is accepted exactly 4 times, then req_ready[1]=0; requesters 0, 2, 3 continue rotating without a gap.
   - Then raise rsp_ready[1]: the 4 results drain in issue order, and requester 1 becomes eligible one cycle after its first pop.
4. Ordering.
   - Stimulus: requester 2 issues ex1 = 3f800000, 40000000, 40400000 with ex2=ex3=0.
   - Required: responses arrive in that order.
5. Reset mid-flight.
   - Stimulus: assert RST with 2 operations in flight.
   - Required: all outputs are 0 immediately; after release, no rsp_valid for 10 cycles with req_valid=0.
6. Credit boundary.
   - Stimulus: requester 3 at cnt=4, pop and req_valid asserted in the same cycle.
   - Required: no grant to requester 3 that cycle; granted on the next edge.

Source files
------------

// File: rtl/fpu_issue_arbiter.sv
// Round-robin issue arbiter sharing one non-stallable pipelined FMA unit among NREQ requesters.
// Results return through per-requester FIFOs; credits reserve a FIFO slot before each issue.
module fpu_issue_arbiter #(
    parameter int NREQ   = 4,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4,
    parameter int IDW    = 2
) (
    input  logic                ACLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [32*NREQ-1:0]  req_ex1,
    input  logic [32*NREQ-1:0]  req_ex2,
    input  logic [32*NREQ-1:0]  req_ex3,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [32*NREQ-1:0]  rsp_data,
    output logic [1:0]          fpu_op,
    output logic [31:0]         fpu_ex1,
    output logic [31:0]         fpu_ex2,
    output logic [31:0]         fpu_ex3,
    output logic                fpu_issue,
    input  logic [31:0]         fpu_exd
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [IDW-1:0] r_rrPtr;
    logic [CW-1:0]  r_cnt [NREQ];
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_push;
    logic [NREQ-1:0] w_pop;
    logic            w_anyGrant;
    logic [IDW-1:0]  w_grantId;

    logic [1:0]  r_fpuOp;
    logic [31:0] r_fpuEx1;
    logic [31:0] r_fpuEx2;
    logic [31:0] r_fpuEx3;
    logic        r_fpuIssue;

    logic [LAT:0]   r_tagValid;
    logic [IDW-1:0] r_tagId [LAT+1];

    logic [31:0]   r_mem   [NREQ][QDEPTH];
    logic [PW-1:0] r_wrPtr [NREQ];
    logic [PW-1:0] r_rdPtr [NREQ];
    logic [CW-1:0] r_occ   [NREQ];

    function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Eligibility looks only at the registered credit count, so a pop never frees a slot the same cycle.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] && (r_cnt[i] < CW'(QDEPTH));
        end
    end

    always_comb begin
        w_grant    = '0;
        w_anyGrant = 1'b0;
        w_grantId  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_anyGrant && w_elig[wrapAdd(r_rrPtr, k)]) begin
                w_anyGrant = 1'b1;
                w_grantId  = wrapAdd(r_rrPtr, k);
            end
        end
        if (w_anyGrant) w_grant[w_grantId] = 1'b1;
    end

    assign req_ready = w_grant;

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            r_rrPtr <= '0;
        end else if (w_anyGrant) begin
            r_rrPtr <= wrapAdd(w_grantId, 1);
        end
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            r_fpuOp    <= '0;
            r_fpuEx1   <= '0;
            r_fpuEx2   <= '0;
            r_fpuEx3   <= '0;
            r_fpuIssue <= 1'b0;
        end else if (w_anyGrant) begin
            r_fpuOp    <= req_op[2*w_grantId +: 2];
            r_fpuEx1   <= req_ex1[32*w_grantId +: 32];
            r_fpuEx2   <= req_ex2[32*w_grantId +: 32];
            r_fpuEx3   <= req_ex3[32*w_grantId +: 32];
            r_fpuIssue <= 1'b1;
        end else begin
            r_fpuOp    <= '0;
            r_fpuEx1   <= '0;
            r_fpuEx2   <= '0;
            r_fpuEx3   <= '0;
            r_fpuIssue <= 1'b0;
        end
    end

    assign fpu_op    = r_fpuOp;
    assign fpu_ex1   = r_fpuEx1;
    assign fpu_ex2   = r_fpuEx2;
    assign fpu_ex3   = r_fpuEx3;
    assign fpu_issue = r_fpuIssue;

    // The tail entry lines up with the FPU result; the push happens one edge later.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            r_tagValid <= '0;
            for (int j = 0; j <= LAT; j++) r_tagId[j] <= '0;
        end else begin
            r_tagValid[0] <= w_anyGrant;
            r_tagId[0]    <= w_grantId;
            for (int j = 1; j <= LAT; j++) begin
                r_tagValid[j] <= r_tagValid[j-1];
                r_tagId[j]    <= r_tagId[j-1];
            end
        end
    end

    always_comb begin
        w_push    = '0;
        w_pop     = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_push[i]    = r_tagValid[LAT] && (r_tagId[LAT] == IDW'(i));
            rsp_valid[i] = (r_occ[i] != '0);
            w_pop[i]     = rsp_valid[i] && rsp_ready[i];
            if (rsp_valid[i]) rsp_data[32*i +: 32] = r_mem[i][r_rdPtr[i]];
        end
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREQ; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
                r_occ[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_push[i]) begin
                    assert (r_occ[i] != CW'(QDEPTH));
                    r_wrPtr[i] <= (r_wrPtr[i] == PW'(QDEPTH - 1)) ? '0 : r_wrPtr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rdPtr[i] <= (r_rdPtr[i] == PW'(QDEPTH - 1)) ? '0 : r_rdPtr[i] + 1'b1;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_occ[i] <= r_occ[i] + 1'b1;
                    2'b01:   r_occ[i] <= r_occ[i] - 1'b1;
                    default: r_occ[i] <= r_occ[i];
                endcase
            end
        end
    end

    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (w_push[i]) r_mem[i][r_wrPtr[i]] <= fpu_exd;
        end
    end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter with a two-stage stand-in for the external FMA pipe.
// Covers latency, rotation, backpressure/credits, per-requester ordering and reset mid-flight.
module tb_fpu_issue_arbiter;

    logic         ACLK = 1'b0;
    logic         RST  = 1'b1;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_op;
    logic [127:0] req_ex1;
    logic [127:0] req_ex2;
    logic [127:0] req_ex3;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [127:0] rsp_data;
    logic [1:0]   fpu_op;
    logic [31:0]  fpu_ex1;
    logic [31:0]  fpu_ex2;
    logic [31:0]  fpu_ex3;
    logic         fpu_issue;
    logic [31:0]  fpu_exd;
    logic [31:0]  fpuStage1;
    logic [31:0]  fpuStage2;

    int checks = 0;
    int errors = 0;

    logic [1:0]  opArr [4];
    logic [31:0] aArr  [4];
    logic [31:0] bArr  [4];
    logic [31:0] cArr  [4];

    always #5 ACLK = ~ACLK;

    fpu_issue_arbiter dut (
        .ACLK      (ACLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ex1   (req_ex1),
        .req_ex2   (req_ex2),
        .req_ex3   (req_ex3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .fpu_op    (fpu_op),
        .fpu_ex1   (fpu_ex1),
        .fpu_ex2   (fpu_ex2),
        .fpu_ex3   (fpu_ex3),
        .fpu_issue (fpu_issue),
        .fpu_exd   (fpu_exd)
    );

    // Only the 1*1+1 vector is a true FMA; other operands get a scrambling function so results stay distinguishable.
    function automatic logic [31:0] fpuModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        if (op == 2'd0 && a == 32'h3f800000 && b == 32'h3f800000 && c == 32'h3f800000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]} ^ ~c ^ {30'd0, op};
    endfunction

    always @(posedge ACLK) begin
        fpuStage1 <= fpuModel(fpu_op, fpu_ex1, fpu_ex2, fpu_ex3);
        fpuStage2 <= fpuStage1;
    end
    assign fpu_exd = fpuStage2;

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] ready);
        req_valid = valid;
        rsp_ready = ready;
        #1;
    endtask

    task automatic setOperands(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c);
        req_op[2*i +: 2]   = op;
        req_ex1[32*i +: 32] = a;
        req_ex2[32*i +: 32] = b;
        req_ex3[32*i +: 32] = c;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic doReset;
        RST = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        tick;
        tick;
        RST = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expG [22];
        int grantsTo1;
        int n1;
        logic [31:0] ord [3];

        req_valid = '0;
        rsp_ready = '0;
        req_op    = '0;
        req_ex1   = '0;
        req_ex2   = '0;
        req_ex3   = '0;
        for (int i = 0; i < 4; i++) begin
            opArr[i] = 2'(i);
            aArr[i]  = 32'h40000000 + (i << 20);
            bArr[i]  = 32'h00010000 * (i + 1);
            cArr[i]  = 32'h11111111 * i;
        end

        #2;
        checkOutput("rst_issue", 32'(fpu_issue), 0);
        checkOutput("rst_op", 32'(fpu_op), 0);
        checkOutput("rst_ex1", fpu_ex1, 0);
        checkOutput("rst_rspValid", 32'(rsp_valid), 0);
        checkOutput("rst_rspData", rsp_data[31:0], 0);
        checkOutput("rst_ready", 32'(req_ready), 0);
        tick;
        tick;
        RST = 1'b0;
        #1;

        $display("[TB] single requester latency");
        setOperands(0, 2'd0, 32'h3f800000, 32'h3f800000, 32'h3f800000);
        applyStimulus(4'b0001, 4'b1111);
        checkOutput("t1_ready", 32'(req_ready), 32'h1);
        tick;
        applyStimulus(4'b0000, 4'b1111);
        checkOutput("t1_issue", 32'(fpu_issue), 1);
        checkOutput("t1_ex1", fpu_ex1, 32'h3f800000);
        checkOutput("t1_op", 32'(fpu_op), 0);
        tick;
        checkOutput("t1_issueLow", 32'(fpu_issue), 0);
        checkOutput("t1_ex1Zero", fpu_ex1, 0);
        checkOutput("t1_noRspE1", 32'(rsp_valid), 0);
        tick;
        checkOutput("t1_noRspE2", 32'(rsp_valid), 0);
        tick;
        checkOutput("t1_rspValid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rspData", rsp_data[31:0], 32'h40000000);
        tick;
        checkOutput("t1_popped", 32'(rsp_valid), 0);
        checkOutput("t1_dataZero", rsp_data[31:0], 0);

        $display("[TB] full contention");
        doReset;
        for (int i = 0; i < 4; i++) setOperands(i, opArr[i], aArr[i], bArr[i], cArr[i]);
        applyStimulus(4'b1111, 4'b1111);
        for (int k = 0; k < 12; k++) begin
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            tick;
            checkOutput("rr_issue", 32'(fpu_issue), 1);
            checkOutput("rr_ex1", fpu_ex1, aArr[k % 4]);
            if (k >= 3) begin
                checkOutput("rr_rspValid", 32'(rsp_valid), 32'(1 << ((k - 3) % 4)));
                checkOutput("rr_rspData", rsp_data[32*((k-3)%4) +: 32],
                            fpuModel(opArr[(k-3)%4], aArr[(k-3)%4], bArr[(k-3)%4], cArr[(k-3)%4]));
            end
        end
        applyStimulus(4'b0000, 4'b1111);
        for (int k = 0; k < 5; k++) tick;

        $display("[TB] backpressure on requester 1");
        doReset;
        expG = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0, 2, 3};
        grantsTo1 = 0;
        n1 = 0;
        for (int i = 0; i < 4; i++) setOperands(i, opArr[i], aArr[i], bArr[i], cArr[i]);
        setOperands(1, opArr[1], 32'h41000000, bArr[1], cArr[1]);
        applyStimulus(4'b1111, 4'b1101);
        for (int k = 0; k < 22; k++) begin
            checkOutput("bp_grant", 32'(req_ready), 32'(1 << expG[k]));
            if (req_ready[1]) grantsTo1++;
            tick;
            checkOutput("bp_issue", 32'(fpu_issue), 1);
            if (expG[k] == 1) begin
                n1++;
                setOperands(1, opArr[1], 32'h41000000 + n1, bArr[1], cArr[1]);
            end
        end
        checkOutput("bp_count1", grantsTo1, 4);
        applyStimulus(4'b0010, 4'b1111);
        checkOutput("bp_noGrantAtPop", 32'(req_ready), 0);
        for (int m = 0; m < 4; m++) begin
            checkOutput("bp_drainValid", 32'(rsp_valid[1]), 1);
            checkOutput("bp_drainData", rsp_data[63:32],
                        fpuModel(opArr[1], 32'h41000000 + m, bArr[1], cArr[1]));
            tick;
            if (m == 0) begin
                checkOutput("bp_eligAfterPop", 32'(req_ready), 32'h2);
                applyStimulus(4'b0000, 4'b1111);
            end
        end
        checkOutput("bp_drained", 32'(rsp_valid[1]), 0);

        $display("[TB] per-requester ordering");
        doReset;
        ord[0] = 32'h3f800000;
        ord[1] = 32'h40000000;
        ord[2] = 32'h40400000;
        setOperands(2, 2'd1, ord[0], 32'h0, 32'h0);
        applyStimulus(4'b0100, 4'b0000);
        checkOutput("ord_ready", 32'(req_ready), 32'h4);
        tick;
        setOperands(2, 2'd1, ord[1], 32'h0, 32'h0);
        tick;
        setOperands(2, 2'd1, ord[2], 32'h0, 32'h0);
        tick;
        applyStimulus(4'b0000, 4'b0000);
        tick;
        tick;
        tick;
        applyStimulus(4'b0000, 4'b0100);
        for (int m = 0; m < 3; m++) begin
            checkOutput("ord_valid", 32'(rsp_valid[2]), 1);
            checkOutput("ord_data", rsp_data[95:64], fpuModel(2'd1, ord[m], 32'h0, 32'h0));
            tick;
        end
        checkOutput("ord_empty", 32'(rsp_valid[2]), 0);

        $display("[TB] reset mid-flight");
        doReset;
        for (int i = 0; i < 4; i++) setOperands(i, opArr[i], aArr[i], bArr[i], cArr[i]);
        applyStimulus(4'b0011, 4'b1111);
        tick;
        tick;
        RST = 1'b1;
        req_valid = '0;
        #1;
        checkOutput("rmf_issue", 32'(fpu_issue), 0);
        checkOutput("rmf_op", 32'(fpu_op), 0);
        checkOutput("rmf_ex1", fpu_ex1, 0);
        checkOutput("rmf_ex2", fpu_ex2, 0);
        checkOutput("rmf_ex3", fpu_ex3, 0);
        checkOutput("rmf_rspValid", 32'(rsp_valid), 0);
        checkOutput("rmf_rspData0", rsp_data[31:0], 0);
        checkOutput("rmf_rspData1", rsp_data[63:32], 0);
        checkOutput("rmf_ready", 32'(req_ready), 0);
        tick;
        tick;
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick;
            checkOutput("rmf_noRsp", 32'(rsp_valid), 0);
        end

        $display("[TB] credit boundary");
        doReset;
        setOperands(3, opArr[3], aArr[3], bArr[3], cArr[3]);
        applyStimulus(4'b1000, 4'b0000);
        for (int k = 0; k < 4; k++) tick;
        checkOutput("cb_full", 32'(req_ready), 0);
        tick;
        tick;
        tick;
        applyStimulus(4'b1000, 4'b1000);
        checkOutput("cb_rspValid", 32'(rsp_valid[3]), 1);
        checkOutput("cb_popSameCycle", 32'(req_ready), 0);
        tick;
        applyStimulus(4'b1000, 4'b0000);
        checkOutput("cb_nextEdge", 32'(req_ready), 32'h8);
        tick;
        checkOutput("cb_issue", 32'(fpu_issue), 1);
        checkOutput("cb_fullAgain", 32'(req_ready), 0);
        applyStimulus(4'b0000, 4'b1111);
        for (int k = 0; k < 8; k++) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
